regfile_wb_arbiter: RTL

- Arbitrates two writeback requesters for the single write port of the 32-bit register file: port A is the ALU/execute result, port B is the load/memory result.
- Round-robin arbitration on contention. Valid/ready handshake per requester.
- Registered write outputs, 1-cycle latency to the register file.
- Writes to x0 are suppressed. A saturating contention counter is provided for debug.

---
 rtl/regfile_wb_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose:
//   Shares the single register-file write port between two writeback
//   requesters: port A (ALU/execute result) and port B (load/memory result).
//   When both request in the same cycle, a round-robin pointer decides who
//   wins. The write to the register file is registered, so it appears one
//   cycle after the grant. Writes to x0 complete the handshake but never
//   assert wr_en. A saturating counter records contention cycles for debug.
//
// Ports:
//   CLK            system clock, rising edge
//   Reset          asynchronous active-high reset
//   hold           pipeline stall; blocks all grants while high
//   a_valid/a_rd/a_data/a_ready   port A request and combinational grant
//   b_valid/b_rd/b_data/b_ready   port B request and combinational grant
//   wr_en/wr_addr/wr_data         registered register-file write port
//   contention_cnt                cycles with both requesting (saturating)
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              hold,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_rd,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_rd,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [CNT_W-1:0]  contention_cnt
);

    // Round-robin pointer: 0 means A wins a tie, 1 means B wins a tie.
    localparam logic PRIO_A = 1'b0;
    localparam logic PRIO_B = 1'b1;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic prio;
    logic grant_a;
    logic grant_b;
    logic both_req;

    assign both_req = a_valid & b_valid & ~hold;

    // Grant decision; Reset is included so no handshake completes during reset.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (Reset || hold) begin
            grant_a = 1'b0;
            grant_b = 1'b0;
        end else if (a_valid && !b_valid) begin
            grant_a = 1'b1;
        end else if (b_valid && !a_valid) begin
            grant_b = 1'b1;
        end else if (a_valid && b_valid) begin
            if (prio == PRIO_B) begin
                grant_b = 1'b1;
            end else begin
                grant_a = 1'b1;
            end
        end else begin
            grant_a = 1'b0;
            grant_b = 1'b0;
        end
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    // Registered write port and round-robin pointer update.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            wr_en   <= 1'b0;
            wr_addr <= {ADDR_W{1'b0}};
            wr_data <= {DATA_W{1'b0}};
            prio    <= PRIO_A;
        end else if (grant_a) begin
            // An x0 destination is accepted but must not reach the file.
            wr_en   <= (a_rd != {ADDR_W{1'b0}});
            wr_addr <= a_rd;
            wr_data <= a_data;
            prio    <= PRIO_B;
        end else if (grant_b) begin
            wr_en   <= (b_rd != {ADDR_W{1'b0}});
            wr_addr <= b_rd;
            wr_data <= b_data;
            prio    <= PRIO_A;
        end else begin
            // Address and data hold so the last write stays observable.
            wr_en   <= 1'b0;
        end
    end

    // Saturating contention counter; stalled cycles are not counted.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            contention_cnt <= {CNT_W{1'b0}};
        end else if (both_req && (contention_cnt != CNT_MAX)) begin
            contention_cnt <= contention_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            contention_cnt <= contention_cnt;
        end
    end

endmodule
